// File: rtl/pof_posit_pkg.sv
// Shared posit types and special-value constants for the encoder pipeline.
package pof_posit_pkg;

    localparam int POSIT_WIDTH_DEF = 16;
    localparam int REG_LEN_W       = $clog2(POSIT_WIDTH_DEF) + 1;

    typedef logic [POSIT_WIDTH_DEF-1:0] posit_t;

    function automatic int reg_len_width(input int n);
        return $clog2(n) + 1;
    endfunction

    function automatic logic [63:0] posit_nar(input int n);
        return 64'd1 << (n - 1);
    endfunction

    function automatic logic [63:0] posit_zero(input int n);
        return 64'(n < 0);
    endfunction

    function automatic logic [63:0] posit_maxpos(input int n);
        return (64'd1 << (n - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] posit_minpos(input int n);
        return 64'(n > 0);
    endfunction

endpackage

// File: rtl/posit_round_rne.sv
// Round-to-nearest-even on the posit body, clamp to [minpos, maxpos], then apply sign.
module posit_round_rne
    import pof_posit_pkg::*;
#(
    parameter int POSIT_WIDTH = 16
) (
    input  logic [POSIT_WIDTH-2:0] body,
    input  logic                   guard,
    input  logic                   sticky,
    input  logic                   sign,
    output logic [POSIT_WIDTH-1:0] posit
);

    localparam int N = POSIT_WIDTH;
    localparam logic [N-1:0] MAXPOS_P = N'(posit_maxpos(N));
    localparam logic [N-1:0] MINPOS_P = N'(posit_minpos(N));

    logic          rnd;
    logic [N-1:0]  mag_inc;
    logic [N-1:0]  mag;

    always_comb begin
        rnd     = guard && (body[0] || sticky);
        mag_inc = {1'b0, body} + {{(N-1){1'b0}}, rnd};
        // a carry into the sign position would alias NaR; a zero body would alias zero
        if (mag_inc[N-1]) begin
            mag = MAXPOS_P;
        end else if (mag_inc == '0) begin
            mag = MINPOS_P;
        end else begin
            mag = mag_inc;
        end
        posit = sign ? (~mag + {{(N-1){1'b0}}, 1'b1}) : mag;
    end

endmodule

// File: rtl/posit_encoder_pipe.sv
// Pipelined posit encoder: (sign, scale, fraction) -> N-bit posit with RNE, 3-cycle latency.
// Define POSIT_ENC_FLAGS_EN to add the out_ovf / out_unf clamp-indication outputs.
module posit_encoder_pipe
    import pof_posit_pkg::*;
#(
    parameter int POSIT_WIDTH   = 16,
    parameter int ES            = 1,
    parameter int FRAC_IN_WIDTH = 16,
    parameter int SCALE_WIDTH   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_sign,
    input  logic                     in_zero,
    input  logic                     in_nar,
    input  logic [SCALE_WIDTH-1:0]   in_scale,
    input  logic [FRAC_IN_WIDTH-1:0] in_frac,
    output logic                     out_valid,
    input  logic                     out_ready,
`ifdef POSIT_ENC_FLAGS_EN
    output logic                     out_ovf,
    output logic                     out_unf,
`endif
    output logic [POSIT_WIDTH-1:0]   out_posit
);

    localparam int N   = POSIT_WIDTH;
    localparam int RLW = reg_len_width(N);
    localparam int TW  = ES + FRAC_IN_WIDTH;
    localparam int MW  = N + 1 + TW;

    localparam logic [N-1:0] NAR_P    = N'(posit_nar(N));
    localparam logic [N-1:0] ZERO_P   = N'(posit_zero(N));
    localparam logic [N-1:0] MAXPOS_P = N'(posit_maxpos(N));
    localparam logic [N-1:0] MINPOS_P = N'(posit_minpos(N));

    logic v1, v2, v3;
    logic adv1, adv2, adv3;

    assign adv3      = !v3 || out_ready;
    assign adv2      = !v2 || adv3;
    assign adv1      = !v1 || adv2;
    assign in_ready  = adv1;
    assign out_valid = v3;

    // ---------------- S1: regime run length and scale clamp ----------------
    logic [TW-1:0] tail_in;

    generate
        if (ES > 0) begin : g_es
            assign tail_in = {in_scale[ES-1:0], in_frac};
        end else begin : g_no_es
            assign tail_in = in_frac;
        end
    endgenerate

    logic signed [SCALE_WIDTH-1:0] k_s;
    int                            k_i;
    int                            r_i;
    logic                          sat_max_d;
    logic                          sat_min_d;
    logic [RLW-1:0]                run_d;

    always_comb begin
        k_s       = $signed(in_scale) >>> ES;
        k_i       = int'(k_s);
        sat_max_d = k_i > N - 2;
        sat_min_d = k_i < -(N - 1);
        r_i       = (k_i >= 0) ? k_i + 1 : -k_i;
        run_d     = (sat_max_d || sat_min_d) ? RLW'(1) : RLW'(r_i);
    end

    logic          sign1, zero1, nar1, smax1, smin1, rbit1;
    logic [RLW-1:0] run1;
    logic [TW-1:0] tail1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            sign1 <= 1'b0;
            zero1 <= 1'b0;
            nar1  <= 1'b0;
            smax1 <= 1'b0;
            smin1 <= 1'b0;
            rbit1 <= 1'b0;
            run1  <= '0;
            tail1 <= '0;
        end else if (adv1) begin
            v1 <= in_valid;
            if (in_valid) begin
                sign1 <= in_sign;
                zero1 <= in_zero;
                nar1  <= in_nar;
                smax1 <= sat_max_d;
                smin1 <= sat_min_d;
                rbit1 <= !k_s[SCALE_WIDTH-1];
                run1  <= run_d;
                tail1 <= tail_in;
            end
        end
    end

    // ---------------- S2: place regime, cut body / guard / sticky ----------------
    logic [RLW-1:0] shamt;
    logic [MW-1:0]  field;
    logic [N-2:0]   body_d;
    logic           guard_d;
    logic           sticky_d;

    always_comb begin
        // run bits of rbit, terminator, then {e, frac}; the shift drops the unused run prefix
        shamt    = RLW'(N) - run1;
        field    = {{N{rbit1}}, ~rbit1, tail1} << shamt;
        body_d   = field[MW-1 -: N-1];
        guard_d  = field[MW-N];
        sticky_d = |field[MW-N-1:0];
        if (smax1) begin
            body_d   = MAXPOS_P[N-2:0];
            guard_d  = 1'b0;
            sticky_d = 1'b0;
        end else if (smin1) begin
            body_d   = MINPOS_P[N-2:0];
            guard_d  = 1'b0;
            sticky_d = 1'b0;
        end
    end

    logic         sign2, zero2, nar2, guard2, sticky2;
    logic [N-2:0] body2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2      <= 1'b0;
            sign2   <= 1'b0;
            zero2   <= 1'b0;
            nar2    <= 1'b0;
            body2   <= '0;
            guard2  <= 1'b0;
            sticky2 <= 1'b0;
        end else if (adv2) begin
            v2 <= v1;
            if (v1) begin
                sign2   <= sign1;
                zero2   <= zero1;
                nar2    <= nar1;
                body2   <= body_d;
                guard2  <= guard_d;
                sticky2 <= sticky_d;
            end
        end
    end

    // ---------------- S3: round, clamp, sign, specials ----------------
    logic [N-1:0] rounded;
    logic [N-1:0] posit_d;
    logic [N-1:0] posit3;

    posit_round_rne #(.POSIT_WIDTH(N)) u_round (
        .body   (body2),
        .guard  (guard2),
        .sticky (sticky2),
        .sign   (sign2),
        .posit  (rounded)
    );

    assign posit_d = nar2 ? NAR_P : (zero2 ? ZERO_P : rounded);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3     <= 1'b0;
            posit3 <= '0;
        end else if (adv3) begin
            v3 <= v2;
            if (v2) begin
                posit3 <= posit_d;
            end
        end
    end

    assign out_posit = posit3;

`ifdef POSIT_ENC_FLAGS_EN
    // an all-zero body means the true magnitude lies below minpos
    logic ovf2, unf2, ovf3, unf3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf2 <= 1'b0;
            unf2 <= 1'b0;
            ovf3 <= 1'b0;
            unf3 <= 1'b0;
        end else begin
            if (adv2 && v1) begin
                ovf2 <= smax1;
                unf2 <= smin1 || (body_d == '0);
            end
            if (adv3 && v2) begin
                ovf3 <= ovf2 && !nar2 && !zero2;
                unf3 <= unf2 && !nar2 && !zero2;
            end
        end
    end

    assign out_ovf = ovf3;
    assign out_unf = unf3;
`endif

endmodule
